msx_mem_arbiter: RTL and testbench

- Shares one single-port main-memory port (BRAM/SDRAM wrapper with req/ack handshake) between two requesters: the T80 CPU and the ROM/cartridge download path.
- The CPU is stalled through the Z80 WAIT_n line until its access completes.
- The download path is back-pressured through a busy flag.
- Sits between the T80/memory_mapper decode and the memory wrapper in the msx1 top level.

---
 rtl/msx_pkg.sv | 13 +
 rtl/msx_req_latch.sv | 69 ++++++
 rtl/msx_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_msx_mem_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_pkg.sv
// Shared types and constants for the MSX main-memory arbiter.
package msx_pkg;

    localparam int unsigned MsxAddrW = 18;
    localparam int unsigned DataW    = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCpuAcc,
        StDlAcc
    } arb_state_e;

endpackage

// File: rtl/msx_req_latch.sv
// One-entry request buffer: captures a request (rising edge of a level, or a
// one-cycle strobe) together with its address/data/we, and holds it pending
// until the arbiter reports completion.
module msx_req_latch
    import msx_pkg::*;
#(
    parameter int unsigned AddrW        = MsxAddrW,
    // 1: req_i is a level and only its rising edge starts a request.
    parameter bit          EdgeDetect   = 1'b1,
    // 1: a new request arriving in the completion cycle refills the buffer.
    parameter bit          ReloadOnDone = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [DataW-1:0] data_i,
    input  logic             done_i,
    output logic             pend_o,
    output logic             we_o,
    output logic [AddrW-1:0] addr_o,
    output logic [DataW-1:0] data_o
);

    logic             req_q;
    logic             pend_q;
    logic             we_q;
    logic [AddrW-1:0] addr_q;
    logic [DataW-1:0] data_q;
    logic             fire;
    logic             accept;

    assign fire   = EdgeDetect ? (req_i & ~req_q) : req_i;
    // Requests arriving while the buffer is occupied are dropped.
    assign accept = fire & (~pend_q | (ReloadOnDone & done_i));

    // Previous-cycle copy of the request line for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_i;
        end
    end

    // Buffer fill on accept, release on completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            pend_q <= 1'b1;
            we_q   <= we_i;
            addr_q <= addr_i;
            data_q <= data_i;
        end else if (done_i) begin
            pend_q <= 1'b0;
        end
    end

    assign pend_o = pend_q;
    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/msx_mem_arbiter.sv
// Shares the single-port main memory between the T80 CPU (stalled via WAIT_n)
// and the cartridge download path (back-pressured via dl_busy). The CPU wins
// ties, but a pending download is forced through after MAX_CPU_RUN
// consecutive CPU grants.
module msx_mem_arbiter
    import msx_pkg::*;
#(
    parameter int unsigned ADDR_W      = MsxAddrW,
    parameter int unsigned MAX_CPU_RUN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_wait_n,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned     RunW   = $clog2(MAX_CPU_RUN + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(MAX_CPU_RUN);

    arb_state_e        state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic [7:0]        cpu_dout_q;
    logic [RunW-1:0]   run_q;

    logic              cpu_pend;
    logic              cpu_we_b;
    logic [ADDR_W-1:0] cpu_addr_b;
    logic [7:0]        cpu_wdata_b;
    logic              dl_pend;
    logic              dl_we_b;
    logic [ADDR_W-1:0] dl_addr_b;
    logic [7:0]        dl_wdata_b;

    logic              cpu_done;
    logic              dl_done;
    logic              grant_cpu;

    assign cpu_done  = (state_q == StCpuAcc) & mem_ack;
    assign dl_done   = (state_q == StDlAcc) & mem_ack;
    assign grant_cpu = cpu_pend & ~(dl_pend & (run_q == RunMax));

    // The CPU buffer may be refilled in its own completion cycle so that
    // back-to-back CPU cycles stay pending across the idle slot.
    msx_req_latch #(
        .AddrW        (ADDR_W),
        .EdgeDetect   (1'b1),
        .ReloadOnDone (1'b1)
    ) u_cpu_latch (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .req_i  (cpu_req),
        .we_i   (cpu_we),
        .addr_i (cpu_addr),
        .data_i (cpu_din),
        .done_i (cpu_done),
        .pend_o (cpu_pend),
        .we_o   (cpu_we_b),
        .addr_o (cpu_addr_b),
        .data_o (cpu_wdata_b)
    );

    msx_req_latch #(
        .AddrW        (ADDR_W),
        .EdgeDetect   (1'b0),
        .ReloadOnDone (1'b0)
    ) u_dl_latch (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .req_i  (dl_wr),
        .we_i   (1'b1),
        .addr_i (dl_addr),
        .data_i (dl_data),
        .done_i (dl_done),
        .pend_o (dl_pend),
        .we_o   (dl_we_b),
        .addr_o (dl_addr_b),
        .data_o (dl_wdata_b)
    );

    // Grant FSM: memory request fields are loaded on grant and held until ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_dout_q  <= '0;
            run_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_cpu) begin
                        state_q     <= StCpuAcc;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= cpu_we_b;
                        mem_addr_q  <= cpu_addr_b;
                        mem_wdata_q <= cpu_wdata_b;
                    end else if (dl_pend) begin
                        state_q     <= StDlAcc;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dl_we_b;
                        mem_addr_q  <= dl_addr_b;
                        mem_wdata_q <= dl_wdata_b;
                    end
                end
                StCpuAcc: begin
                    if (mem_ack) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            cpu_dout_q <= mem_rdata;
                        end
                        // Count CPU wins only while a download is waiting.
                        if (dl_pend) begin
                            run_q <= (run_q == RunMax) ? RunMax : run_q + 1'b1;
                        end else begin
                            run_q <= '0;
                        end
                    end
                end
                StDlAcc: begin
                    if (mem_ack) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                        run_q     <= '0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_dout   = cpu_dout_q;
    assign cpu_wait_n = ~cpu_pend;
    assign dl_busy    = dl_pend;

endmodule

// File: tb/tb_msx_mem_arbiter.sv
// Directed bench for msx_mem_arbiter with a behavioural memory wrapper that
// acks each request a programmable number of cycles after it is raised.
module tb_msx_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [17:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_wait_n;
    logic        dl_wr;
    logic [17:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_busy;
    logic        mem_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int total;
    int bad;
    int ack_delay;

    // Preload contents (written by the stimulus) and memory writes (written
    // by the wrapper model) are kept apart so each has a single writer.
    logic [7:0] pre  [logic [17:0]];
    logic [7:0] wmem [logic [17:0]];

    // Wrapper model bookkeeping.
    int          cnt;
    int          rises;
    int          stab_err;
    bit          prev_req;
    logic        s_we;
    logic [17:0] s_addr;
    logic [7:0]  s_wdata;
    logic        log_we    [$];
    logic [17:0] log_addr  [$];
    logic [7:0]  log_wdata [$];

    msx_mem_arbiter #(
        .ADDR_W      (18),
        .MAX_CPU_RUN (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_wait_n (cpu_wait_n),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_busy    (dl_busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [17:0] a);
        if (wmem.exists(a)) return wmem[a];
        if (pre.exists(a)) return pre[a];
        return 8'h00;
    endfunction

    // Memory wrapper: ack in the (ack_delay+1)-th cycle of mem_req, log each
    // new request and flag any change of the request fields while pending.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        cnt       = 0;
        rises     = 0;
        stab_err  = 0;
        prev_req  = 1'b0;
        s_we      = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack   = 1'b0;
                mem_rdata = 8'h00;
            end
            if (!mem_req || !reset_n) begin
                cnt = 0;
            end else begin
                if (!prev_req) begin
                    rises++;
                    s_we    = mem_we;
                    s_addr  = mem_addr;
                    s_wdata = mem_wdata;
                    log_we.push_back(mem_we);
                    log_addr.push_back(mem_addr);
                    log_wdata.push_back(mem_wdata);
                end else if (mem_we !== s_we || mem_addr !== s_addr ||
                             mem_wdata !== s_wdata) begin
                    stab_err++;
                end
                cnt++;
                if (cnt == ack_delay + 1) begin
                    mem_ack = 1'b1;
                    if (mem_we) wmem[mem_addr] = mem_wdata;
                    else mem_rdata = mem_rd(mem_addr);
                end
            end
            prev_req = mem_req;
        end
    end

    task automatic cpu_access(input logic we, input logic [17:0] addr, input logic [7:0] din,
                              output logic [7:0] dout, output int low, output bit tmo);
        bit done;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_din  = din;
        low  = 0;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!cpu_wait_n) low++;
            else if (low > 0) begin
                done = 1'b1;
                break;
            end
        end
        dout    = cpu_dout;
        tmo     = ~done;
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        total++; if (dl_busy !== 1'b0) begin bad++; $display("FAIL rst_dl_busy: got %b want 0", dl_busy); end
        total++; if (cpu_wait_n !== 1'b1) begin bad++; $display("FAIL rst_wait_n: got %b want 1", cpu_wait_n); end
        total++; if (cpu_dout !== 8'h00) begin bad++; $display("FAIL rst_dout: got %h want 00", cpu_dout); end
        total++; if (mem_addr !== 18'h0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        total++; if (mem_wdata !== 8'h00) begin bad++; $display("FAIL rst_mem_wdata: got %h want 00", mem_wdata); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cpu_read();
        logic [7:0] d;
        int low;
        bit tmo;
        int lb;
        int rb;
        pre[18'h00100] = 8'hA5;
        ack_delay = 3;
        lb = log_addr.size();
        rb = rises;
        cpu_access(1'b0, 18'h00100, 8'h00, d, low, tmo);
        total++; if (tmo) begin bad++; $display("FAIL cpu_read_timeout: got timeout want completion"); end
        total++; if (low !== 5) begin bad++; $display("FAIL cpu_read_wait_cycles: got %0d want 5", low); end
        total++; if (d !== 8'hA5) begin bad++; $display("FAIL cpu_read_dout: got %h want a5", d); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL cpu_read_req_drop: got %b want 0", mem_req); end
        repeat (3) @(negedge clk);
        total++; if (rises - rb !== 1) begin bad++; $display("FAIL cpu_read_nreq: got %0d want 1", rises - rb); end
        if (log_addr.size() > lb) begin
            total++; if (log_addr[lb] !== 18'h00100 || log_we[lb] !== 1'b0) begin
                bad++; $display("FAIL cpu_read_req_fields: got addr %h we %b want 00100 0",
                                log_addr[lb], log_we[lb]);
            end
        end
    endtask

    task automatic test_download();
        int busy;
        int rb;
        pre[18'h04001] = 8'h99;
        ack_delay = 3;
        rb = rises;
        @(negedge clk);
        dl_wr = 1'b1; dl_addr = 18'h04000; dl_data = 8'h3C;
        @(negedge clk);
        busy = dl_busy ? 1 : 0;
        total++; if (dl_busy !== 1'b1) begin bad++; $display("FAIL dl_busy_set: got %b want 1", dl_busy); end
        dl_addr = 18'h04001; dl_data = 8'h77;  // strobe while busy: must be dropped
        @(negedge clk);
        dl_wr = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            bad++; $display("FAIL dl_req: got req %b we %b want 1 1", mem_req, mem_we);
        end
        total++; if (mem_addr !== 18'h04000 || mem_wdata !== 8'h3C) begin
            bad++; $display("FAIL dl_fields: got %h/%h want 04000/3c", mem_addr, mem_wdata);
        end
        for (int i = 0; i < 50 && dl_busy; i++) begin
            busy++;
            @(negedge clk);
        end
        total++; if (busy !== 5) begin bad++; $display("FAIL dl_busy_cycles: got %0d want 5", busy); end
        repeat (4) @(negedge clk);
        total++; if (rises - rb !== 1) begin bad++; $display("FAIL dl_nreq: got %0d want 1", rises - rb); end
        total++; if (mem_rd(18'h04000) !== 8'h3C) begin bad++; $display("FAIL dl_mem_written: got %h want 3c", mem_rd(18'h04000)); end
        total++; if (mem_rd(18'h04001) !== 8'h99) begin bad++; $display("FAIL dl_drop_busy: got %h want 99", mem_rd(18'h04001)); end
    endtask

    task automatic test_dl_ack_collision();
        int rb;
        pre[18'h04003] = 8'h99;
        ack_delay = 3;
        rb = rises;
        @(negedge clk);
        dl_wr = 1'b1; dl_addr = 18'h04002; dl_data = 8'h55;
        @(negedge clk);
        dl_wr = 1'b0;
        repeat (4) @(negedge clk);
        // This is the ack cycle of the buffered write.
        total++; if (dl_busy !== 1'b1) begin bad++; $display("FAIL coll_busy_in_ack: got %b want 1", dl_busy); end
        dl_wr = 1'b1; dl_addr = 18'h04003; dl_data = 8'h66;
        @(negedge clk);
        dl_wr = 1'b0;
        total++; if (dl_busy !== 1'b0) begin bad++; $display("FAIL coll_busy_after: got %b want 0", dl_busy); end
        repeat (6) @(negedge clk);
        total++; if (rises - rb !== 1) begin bad++; $display("FAIL coll_nreq: got %0d want 1", rises - rb); end
        total++; if (mem_rd(18'h04002) !== 8'h55) begin bad++; $display("FAIL coll_first: got %h want 55", mem_rd(18'h04002)); end
        total++; if (mem_rd(18'h04003) !== 8'h99) begin bad++; $display("FAIL coll_dropped: got %h want 99", mem_rd(18'h04003)); end
    endtask

    task automatic test_simultaneous();
        int lb;
        int rb;
        bit ok;
        ack_delay = 2;
        lb = log_addr.size();
        rb = rises;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00000; cpu_din = 8'h11;
        dl_wr = 1'b1; dl_addr = 18'h00001; dl_data = 8'h22;
        @(negedge clk);
        dl_wr = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_wait_n) cpu_req = 1'b0;
            if (cpu_wait_n && !dl_busy) begin
                ok = 1'b1;
                break;
            end
        end
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (!ok) begin bad++; $display("FAIL sim_timeout: got timeout want completion"); end
        total++; if (rises - rb !== 2) begin bad++; $display("FAIL sim_nreq: got %0d want 2", rises - rb); end
        if (log_addr.size() >= lb + 2) begin
            total++; if (log_addr[lb] !== 18'h0 || log_wdata[lb] !== 8'h11) begin
                bad++; $display("FAIL sim_first_cpu: got %h/%h want 00000/11", log_addr[lb], log_wdata[lb]);
            end
            total++; if (log_addr[lb+1] !== 18'h1 || log_wdata[lb+1] !== 8'h22) begin
                bad++; $display("FAIL sim_second_dl: got %h/%h want 00001/22", log_addr[lb+1], log_wdata[lb+1]);
            end
        end
    endtask

    task automatic test_starvation();
        logic [17:0] exp_a [6];
        logic        exp_w [6];
        int lb;
        bit ok;
        exp_a[0] = 18'h00010; exp_w[0] = 1'b0;
        exp_a[1] = 18'h00011; exp_w[1] = 1'b0;
        exp_a[2] = 18'h00012; exp_w[2] = 1'b0;
        exp_a[3] = 18'h00013; exp_w[3] = 1'b0;
        exp_a[4] = 18'h04100; exp_w[4] = 1'b1;
        exp_a[5] = 18'h00014; exp_w[5] = 1'b0;
        pre[18'h00014] = 8'h5A;
        ack_delay = 1;
        lb = log_addr.size();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00010;
        dl_wr = 1'b1; dl_addr = 18'h04100; dl_data = 8'hEE;
        @(negedge clk);
        dl_wr = 1'b0;
        // Drop cpu_req during each granted access and raise it again in the
        // ack cycle so the next CPU cycle is already pending at the idle slot.
        for (int i = 1; i <= 4; i++) begin
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (mem_req) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                total++; bad++; $display("FAIL starve_grant_timeout: got no grant want grant %0d", i);
                break;
            end
            cpu_req = 1'b0;
            @(negedge clk);
            cpu_req  = 1'b1;
            cpu_addr = 18'h00010 + 18'(i);
        end
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cpu_wait_n) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL starve_timeout: got timeout want completion"); end
        total++; if (cpu_dout !== 8'h5A) begin bad++; $display("FAIL starve_dout: got %h want 5a", cpu_dout); end
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (log_addr.size() - lb !== 6) begin
            bad++; $display("FAIL starve_ngrant: got %0d want 6", log_addr.size() - lb);
        end
        for (int i = 0; i < 6 && lb + i < log_addr.size(); i++) begin
            total++; if (log_addr[lb+i] !== exp_a[i] || log_we[lb+i] !== exp_w[i]) begin
                bad++; $display("FAIL starve_order[%0d]: got %h we %b want %h we %b", i,
                                log_addr[lb+i], log_we[lb+i], exp_a[i], exp_w[i]);
            end
        end
        total++; if (mem_rd(18'h04100) !== 8'hEE) begin bad++; $display("FAIL starve_dl_data: got %h want ee", mem_rd(18'h04100)); end
        total++; if (dut.run_q !== 3'd0) begin bad++; $display("FAIL starve_run_clear: got %0d want 0", dut.run_q); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int low;
        bit tmo;
        bit ok;
        int rb;
        ack_delay = 10;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00180;
        dl_wr = 1'b1; dl_addr = 18'h04200; dl_data = 8'h44;
        @(negedge clk);
        dl_wr = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL rmid_grant_timeout: got no grant want grant"); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rmid_mem_req: got %b want 0", mem_req); end
        total++; if (cpu_wait_n !== 1'b1) begin bad++; $display("FAIL rmid_wait_n: got %b want 1", cpu_wait_n); end
        total++; if (dl_busy !== 1'b0) begin bad++; $display("FAIL rmid_dl_busy: got %b want 0", dl_busy); end
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        pre[18'h00200] = 8'h6B;
        ack_delay = 2;
        rb = rises;
        cpu_access(1'b0, 18'h00200, 8'h00, d, low, tmo);
        total++; if (tmo) begin bad++; $display("FAIL rmid_after_timeout: got timeout want completion"); end
        total++; if (d !== 8'h6B) begin bad++; $display("FAIL rmid_after_dout: got %h want 6b", d); end
        total++; if (low !== 4) begin bad++; $display("FAIL rmid_after_wait: got %0d want 4", low); end
        repeat (4) @(negedge clk);
        total++; if (rises - rb !== 1) begin bad++; $display("FAIL rmid_after_nreq: got %0d want 1", rises - rb); end
    endtask

    task automatic test_back_pressure();
        logic [7:0] d;
        int low;
        bit tmo;
        int sb;
        ack_delay = 20;
        sb = stab_err;
        cpu_access(1'b1, 18'h3FFFF, 8'hC3, d, low, tmo);
        total++; if (tmo) begin bad++; $display("FAIL bp_timeout: got timeout want completion"); end
        total++; if (low !== 22) begin bad++; $display("FAIL bp_wait_cycles: got %0d want 22", low); end
        total++; if (stab_err - sb !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", stab_err - sb); end
        total++; if (mem_rd(18'h3FFFF) !== 8'hC3) begin bad++; $display("FAIL bp_mem: got %h want c3", mem_rd(18'h3FFFF)); end
        total++; if (cpu_dout !== 8'h6B) begin bad++; $display("FAIL bp_dout_held: got %h want 6b", cpu_dout); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        ack_delay = 3;
        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_din   = '0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        test_reset();
        test_cpu_read();
        test_download();
        test_dl_ack_collision();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_back_pressure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
